eye_centroid_calc: RTL and testbench

//  Frame-level centroid engine feeding the EyeTracker register block. Thresholds the camera pixel stream,

---
 rtl/eye_centroid_calc_pkg.sv | 16 +
 rtl/eye_serial_div.sv | 60 ++++++
 rtl/eye_centroid_calc.sv | 181 ++++++++++++++++++
 tb/tb_eye_centroid_calc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/eye_centroid_calc_pkg.sv
// Shared widths and sequencing-FSM encoding for the eye centroid engine.
package eye_centroid_calc_pkg;
  localparam int PIX_W    = 8;
  localparam int X_W      = 10;
  localparam int Y_W      = 10;
  localparam int SUM_S_W  = 20;
  localparam int SUM_SX_W = 28;
  localparam int SUM_SY_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV_X  = 2'd1,
    ST_DIV_Y  = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;
endpackage

// File: rtl/eye_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, MSB first; the start
// cycle already performs the first iteration, so the result is ready DIVIDEND_W cycles later.
module eye_serial_div #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 20
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  iSTART,
  input  logic [DIVIDEND_W-1:0] iDIVIDEND,
  input  logic [DIVISOR_W-1:0]  iDIVISOR,
  output logic [DIVIDEND_W-1:0] oQUOTIENT,
  output logic                  oVALID
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVIDEND_W-1:0] rem_q, quo_q, dvs_q;
  logic [DIVIDEND_W-1:0] src_rem, src_quo, src_dvs, rem_d, quo_d, trial;
  logic [DIVIDEND_W:0]   shifted;
  logic [CNT_W-1:0]      cnt_q;
  logic                  zero_q, valid_q, ge;

  always_comb begin
    src_rem = iSTART ? '0 : rem_q;
    src_quo = iSTART ? iDIVIDEND : quo_q;
    src_dvs = iSTART ? DIVIDEND_W'(iDIVISOR) : dvs_q;
    shifted = {src_rem, src_quo[DIVIDEND_W-1]};
    ge      = shifted >= {1'b0, src_dvs};
    trial   = shifted[DIVIDEND_W-1:0] - src_dvs;
    rem_d   = ge ? trial : shifted[DIVIDEND_W-1:0];
    quo_d   = {src_quo[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (iSTART) begin
      cnt_q   <= CNT_W'(DIVIDEND_W - 1);
      zero_q  <= (iDIVISOR == '0);
      valid_q <= 1'b0;
    end else begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      valid_q <= (cnt_q == CNT_W'(1));
    end
  end

  // Datapath registers carry no reset; they are always reloaded by iSTART before use.
  always_ff @(posedge CLK) begin
    if (iSTART || cnt_q != '0) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
    if (iSTART) dvs_q <= src_dvs;
  end

  assign oQUOTIENT = zero_q ? '0 : quo_q;
  assign oVALID    = valid_q;
endmodule

// File: rtl/eye_centroid_calc.sv
// Frame centroid engine: thresholds the pixel stream, accumulates dark-pixel
// count and X/Y sums, latches them at frame end and serially divides for the centroid.
module eye_centroid_calc
  import eye_centroid_calc_pkg::*;
#(
  parameter int PIX_WIDTH    = PIX_W,
  parameter int X_WIDTH      = X_W,
  parameter int Y_WIDTH      = Y_W,
  parameter int SUM_S_WIDTH  = SUM_S_W,
  parameter int SUM_SX_WIDTH = SUM_SX_W,
  parameter int SUM_SY_WIDTH = SUM_SY_W
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    iVSYNC,
  input  logic                    iDE,
  input  logic [PIX_WIDTH-1:0]    iPIXEL,
  input  logic [PIX_WIDTH-1:0]    iTHRESHOLD,
  output logic [SUM_S_WIDTH-1:0]  oSUM_S,
  output logic [SUM_SX_WIDTH-1:0] oSUM_SX,
  output logic [SUM_SY_WIDTH-1:0] oSUM_SY,
  output logic [SUM_SX_WIDTH-1:0] oQUOTIENT_SX,
  output logic [SUM_SY_WIDTH-1:0] oQUOTIENT_SY,
  output logic                    oDONE
);
  localparam int DIV_W = SUM_SX_WIDTH;

  function automatic logic [X_WIDTH-1:0] sat_inc_x(input logic [X_WIDTH-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  function automatic logic [Y_WIDTH-1:0] sat_inc_y(input logic [Y_WIDTH-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  function automatic logic [SUM_S_WIDTH-1:0] sat_inc_s(input logic [SUM_S_WIDTH-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  function automatic logic [SUM_SX_WIDTH-1:0] sat_add_sx(input logic [SUM_SX_WIDTH-1:0] a,
                                                          input logic [X_WIDTH-1:0] b);
    logic [SUM_SX_WIDTH:0] t;
    t = {1'b0, a} + (SUM_SX_WIDTH+1)'(b);
    return t[SUM_SX_WIDTH] ? '1 : t[SUM_SX_WIDTH-1:0];
  endfunction

  function automatic logic [SUM_SY_WIDTH-1:0] sat_add_sy(input logic [SUM_SY_WIDTH-1:0] a,
                                                          input logic [Y_WIDTH-1:0] b);
    logic [SUM_SY_WIDTH:0] t;
    t = {1'b0, a} + (SUM_SY_WIDTH+1)'(b);
    return t[SUM_SY_WIDTH] ? '1 : t[SUM_SY_WIDTH-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic                    vsync_q, de_q, armed_q, kick_q, done_q;
  logic [PIX_WIDTH-1:0]    thr_q;
  logic [X_WIDTH-1:0]      x_q;
  logic [Y_WIDTH-1:0]      y_q;
  logic [SUM_S_WIDTH-1:0]  acc_s_q, sum_s_q;
  logic [SUM_SX_WIDTH-1:0] acc_sx_q, sum_sx_q, quo_sx_q, qx_hold_q;
  logic [SUM_SY_WIDTH-1:0] acc_sy_q, sum_sy_q, quo_sy_q;
  logic                    rise, fall, accept, pix_hit, x_done, y_done, upd;
  logic                    div_start, div_valid;
  logic [DIV_W-1:0]        div_dividend, div_quo;

  assign rise    = iVSYNC & ~vsync_q;
  assign fall    = ~iVSYNC & vsync_q;
  assign accept  = rise & armed_q;
  assign pix_hit = armed_q & iDE & ~rise & (iPIXEL < thr_q);

  // kick_q holds off a stale divider valid during the cycle right after a (re)start.
  assign x_done       = (state_q == ST_DIV_X) & div_valid & ~kick_q;
  assign y_done       = (state_q == ST_DIV_Y) & div_valid;
  assign upd          = y_done & ~accept;
  assign div_start    = kick_q | x_done;
  assign div_dividend = kick_q ? sum_sx_q : DIV_W'(sum_sy_q);

  eye_serial_div #(
    .DIVIDEND_W (DIV_W),
    .DIVISOR_W  (SUM_S_WIDTH)
  ) u_div (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .iSTART    (div_start),
    .iDIVIDEND (div_dividend),
    .iDIVISOR  (sum_s_q),
    .oQUOTIENT (div_quo),
    .oVALID    (div_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_DIV_X:  if (x_done) state_d = ST_DIV_Y;
      ST_DIV_Y:  if (y_done) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (accept) state_d = ST_DIV_X;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Frame front end: edge detect, coordinate counters, saturating accumulators.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vsync_q  <= 1'b1;
      de_q     <= 1'b0;
      armed_q  <= 1'b0;
      thr_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_s_q  <= '0;
      acc_sx_q <= '0;
      acc_sy_q <= '0;
    end else begin
      vsync_q <= iVSYNC;
      de_q    <= iDE;
      if (fall) begin
        armed_q  <= 1'b1;
        thr_q    <= iTHRESHOLD;
        x_q      <= '0;
        y_q      <= '0;
        acc_s_q  <= '0;
        acc_sx_q <= '0;
        acc_sy_q <= '0;
      end else begin
        if (iDE) begin
          x_q <= sat_inc_x(x_q);
        end else if (de_q) begin
          x_q <= '0;
          y_q <= sat_inc_y(y_q);
        end
        if (pix_hit) begin
          acc_s_q  <= sat_inc_s(acc_s_q);
          acc_sx_q <= sat_add_sx(acc_sx_q, x_q);
          acc_sy_q <= sat_add_sy(acc_sy_q, y_q);
        end
        if (accept) armed_q <= 1'b0;
      end
    end
  end

  // Result side: frame sums at frame end, quotients only in the update cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sum_s_q   <= '0;
      sum_sx_q  <= '0;
      sum_sy_q  <= '0;
      quo_sx_q  <= '0;
      quo_sy_q  <= '0;
      qx_hold_q <= '0;
      kick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      kick_q <= accept;
      done_q <= upd;
      if (accept) begin
        sum_s_q  <= acc_s_q;
        sum_sx_q <= acc_sx_q;
        sum_sy_q <= acc_sy_q;
      end
      if (x_done) qx_hold_q <= div_quo;
      if (upd) begin
        quo_sx_q <= qx_hold_q;
        quo_sy_q <= SUM_SY_WIDTH'(div_quo);
      end
    end
  end

  assign oSUM_S       = sum_s_q;
  assign oSUM_SX      = sum_sx_q;
  assign oSUM_SY      = sum_sy_q;
  assign oQUOTIENT_SX = quo_sx_q;
  assign oQUOTIENT_SY = quo_sy_q;
  assign oDONE        = done_q;
endmodule

// File: tb/tb_eye_centroid_calc.sv
// Bench for eye_centroid_calc: table of frames with scoreboarded results,
// plus hand sequences for division restart and mid-division reset.
`timescale 1ns/1ps
module tb_eye_centroid_calc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync, de;
  logic [7:0]  pixel, thr;
  logic [19:0] sum_s;
  logic [27:0] sum_sx, sum_sy, q_sx, q_sy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eye_centroid_calc dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .iVSYNC       (vsync),
    .iDE          (de),
    .iPIXEL       (pixel),
    .iTHRESHOLD   (thr),
    .oSUM_S       (sum_s),
    .oSUM_SX      (sum_sx),
    .oSUM_SY      (sum_sy),
    .oQUOTIENT_SX (q_sx),
    .oQUOTIENT_SY (q_sy),
    .oDONE        (done)
  );

  typedef struct {
    int         w, h, kind;
    logic [7:0] thr;
    bit         chg;
    int         s, sx, sy, qx, qy;
  } vec_t;

  typedef struct {
    int due, s, sx, sy, qx, qy;
  } exp_t;

  vec_t vec[7];
  exp_t sb[$];
  exp_t e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int kind, input int x, input int y);
    case (kind)
      0:       return ((x == 1 || x == 3) && y == 2) ? 8'h7F : 8'h80;
      1:       return 8'h00;
      2:       return 8'hFF;
      3:       return (x >= 2 && y >= 1) ? 8'h00 : 8'hFF;
      4:       return ((x == 5 && y == 3) || (x == 0 && y == 0) || (x == 2 && y == 1)) ? 8'h10 : 8'hF0;
      5:       return 8'h40;
      default: return (x == 1 || x == 2) ? 8'h00 : 8'hFF;
    endcase
  endfunction

  task automatic frame_start(input logic [7:0] t);
    thr   = t;
    vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic drive_lines(input int w, input int h, input int kind, input bit chg);
    for (int y = 0; y < h; y++) begin
      if (chg && y == 1) thr = 8'h00;
      for (int x = 0; x < w; x++) begin
        de    = 1'b1;
        pixel = pix(kind, x, y);
        tick();
      end
      de    = 1'b0;
      pixel = 8'h00;
      tick();
      tick();
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
    chk(name, sb.size(), 0);
  endtask

  // Every oDONE pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      chk("done_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("sum_s", sum_s, e.s);
        chk("sum_sx", sum_sx, e.sx);
        chk("sum_sy", sum_sy, e.sy);
        chk("quot_x", q_sx, e.qx);
        chk("quot_y", q_sy, e.qy);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ra, rr;
    vec[0] = '{4, 4, 0, 8'h80, 1'b0, 2, 4, 4, 2, 2};
    vec[1] = '{6, 4, 3, 8'h80, 1'b0, 12, 42, 24, 3, 2};
    vec[2] = '{6, 4, 4, 8'h80, 1'b0, 3, 7, 4, 2, 1};
    vec[3] = '{4, 4, 2, 8'h80, 1'b0, 0, 0, 0, 0, 0};
    vec[4] = '{4, 4, 5, 8'h80, 1'b1, 16, 24, 24, 1, 1};
    vec[5] = '{4, 4, 1, 8'h00, 1'b0, 0, 0, 0, 0, 0};
    vec[6] = '{160, 120, 1, 8'h01, 1'b0, 19200, 1526400, 1142400, 79, 59};

    rst_n = 1'b0;
    vsync = 1'b1;
    de    = 1'b0;
    pixel = 8'h00;
    thr   = 8'h80;
    tick();
    tick();
    chk("rst_sum_s", sum_s, 0);
    chk("rst_sum_sx", sum_sx, 0);
    chk("rst_sum_sy", sum_sy, 0);
    chk("rst_quot_x", q_sx, 0);
    chk("rst_quot_y", q_sy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) begin
      frame_start(vec[i].thr);
      drive_lines(vec[i].w, vec[i].h, vec[i].kind, vec[i].chg);
      vsync = 1'b1;
      sb.push_back('{cyc + 58, vec[i].s, vec[i].sx, vec[i].sy, vec[i].qx, vec[i].qy});
      tick();
      repeat (70) tick();
      drain("table_drain");
    end

    // Second frame end 20 cycles into the division: only the new frame completes.
    frame_start(8'h80);
    drive_lines(4, 4, 0, 1'b0);
    vsync = 1'b1;
    ra = cyc;
    tick();
    repeat (4) tick();
    vsync = 1'b0;
    tick();
    tick();
    drive_lines(4, 1, 7, 1'b0);
    while (cyc < ra + 20) tick();
    vsync = 1'b1;
    sb.push_back('{cyc + 58, 2, 3, 0, 1, 0});
    tick();
    chk("restart_sum_sx_now", sum_sx, 3);
    while (cyc < ra + 58) tick();
    chk("abort_keeps_qx", q_sx, 79);
    chk("abort_keeps_qy", q_sy, 59);
    drain("restart_drain");

    // Reset in the middle of the Y division, then a normal frame afterwards.
    frame_start(8'h80);
    drive_lines(6, 4, 3, 1'b0);
    vsync = 1'b1;
    rr = cyc;
    tick();
    while (cyc < rr + 31) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_sum_s", sum_s, 0);
    chk("midrst_sum_sx", sum_sx, 0);
    chk("midrst_sum_sy", sum_sy, 0);
    chk("midrst_quot_x", q_sx, 0);
    chk("midrst_quot_y", q_sy, 0);
    chk("midrst_done", done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (70) tick();
    chk("postrst_quot_x", q_sx, 0);
    chk("postrst_sum_s", sum_s, 0);

    frame_start(8'h80);
    drive_lines(6, 4, 4, 1'b0);
    vsync = 1'b1;
    sb.push_back('{cyc + 58, 3, 7, 4, 2, 1});
    tick();
    repeat (70) tick();
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
